// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM states,
// the queued command record and the JK next-state rule.
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] len;
    } cmd_t;

    // Latch state after one cycle of the given {j,k} drive.
    function automatic logic jk_apply(input logic q, input logic [1:0] jk);
        logic q_new;
        case (jk)
            OP_HOLD: q_new = q;
            OP_RST:  q_new = 1'b0;
            OP_SET:  q_new = 1'b1;
            default: q_new = ~q;
        endcase
        return q_new;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two, 2..16), extra-bit pointers for
// full/empty. The head entry is visible combinationally so a pop edge can load it.
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;
    cmd_t        entry [DEPTH];

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // One storage register per slot; only the slot under the write pointer loads.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        cmd_t slot_reg;

        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                slot_reg <= push_data;
            end
        end

        assign entry[gi] = slot_reg;
    end

    assign head = entry[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK latch command sequencer: queues {op,len} commands and drives registered
// j/k for len+1 cycles each, predicting the latch state and flagging disagreement.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_len,
    output logic       j,
    output logic       k,
    input  logic       q_fb,
    output logic       q_pred,
    output logic       busy,
    output logic       mismatch
);

    state_t     state_reg,    state_next;
    logic [2:0] cnt_reg,      cnt_next;
    logic [1:0] jk_reg,       jk_next;
    logic       q_pred_reg,   q_pred_next;
    logic       cmp_en_reg,   cmp_en_next;
    logic       mismatch_reg, mismatch_next;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    cmd_t fifo_head;
    cmd_t push_data;

    assign push_data = {cmd_op, cmd_len};

    jk_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid),
        .push_data(push_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Ready is purely !full so a full queue refuses even on a pop cycle.
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = !fifo_empty && ((state_reg == ST_IDLE) || (cnt_reg == 3'd0));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        jk_next    = jk_reg;
        if (fifo_pop) begin
            state_next = ST_DRIVE;
            cnt_next   = fifo_head.len;
            jk_next    = fifo_head.op;
        end else if (state_reg == ST_IDLE) begin
            jk_next = OP_HOLD;
        end else if (cnt_reg == 3'd0) begin
            state_next = ST_IDLE;
            jk_next    = OP_HOLD;
        end else begin
            cnt_next = cnt_reg - 3'd1;
        end
    end

    // Feedback is only trusted once the prediction has been stable for a cycle.
    always_comb begin
        q_pred_next   = jk_apply(q_pred_reg, jk_reg);
        cmp_en_next   = (q_pred_next == q_pred_reg);
        mismatch_next = mismatch_reg | (cmp_en_reg && (q_fb != q_pred_reg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 3'd0;
            jk_reg       <= OP_HOLD;
            q_pred_reg   <= 1'b0;
            cmp_en_reg   <= 1'b0;
            mismatch_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            jk_reg       <= jk_next;
            q_pred_reg   <= q_pred_next;
            cmp_en_reg   <= cmp_en_next;
            mismatch_reg <= mismatch_next;
        end
    end

    assign j        = jk_reg[1];
    assign k        = jk_reg[0];
    assign q_pred   = q_pred_reg;
    assign mismatch = mismatch_reg;
    assign busy     = (state_reg == ST_DRIVE) || !fifo_empty;

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth in entries; must be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-006 cmd_op  input  2  {j,k} pattern: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 cmd_len  input  3  drive duration minus one, giving 1..8 cycles.
REQ-008 j  output  1  registered J drive to the downstream JK latch.
REQ-009 k  output  1  registered K drive to the downstream JK latch.
REQ-010 q_fb  input  1  q returned from the downstream latch.
REQ-011 q_pred  output  1  registered predicted latch state.
REQ-012 busy  output  1  1 while in DRIVE or while the FIFO is non-empty.
REQ-013 mismatch  output  1  sticky flag: q_fb disagreed with q_pred.

Function
REQ-014 The block SHALL accept a command at a rising edge when cmd_valid and cmd_ready are both 1.
REQ-015 cmd_ready SHALL equal NOT full, with no dependence on a same-cycle pop; a full FIFO never accepts, even while popping.
REQ-016 The FIFO SHALL store {cmd_op, cmd_len} in order; pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer bit.
REQ-017 The FSM SHALL have two states, IDLE and DRIVE.
- IDLE: j=k=0.
- IDLE with FIFO non-empty: pop at the next edge, load j,k from op and cnt from len, then enter DRIVE.
REQ-018 In DRIVE, j,k SHALL hold the popped op, and cnt SHALL decrement each cycle.
- cnt==0 with FIFO non-empty: pop the next command at that edge; DRIVE continues with no bubble cycle.
- cnt==0 with FIFO empty: enter IDLE; j=k=0.
REQ-019 Latency: a command accepted at edge N into an empty FIFO while IDLE SHALL drive j,k from edge N+1 for exactly len+1 cycles.
REQ-020 At each edge where the current j,k were driven, q_pred SHALL update per the JK table: 00 keep, 01 0, 10 1, 11 invert.
- j,k are driven in DRIVE, and also in IDLE, where they are 00 and q_pred therefore holds.
- Toggle SHALL invert q_pred once per cycle.
REQ-021 A compare-enable flag cmp_en SHALL be 1 only when q_pred did not change at the previous edge.
REQ-022 At each edge with cmp_en=1 and q_fb != q_pred, mismatch SHALL set; it SHALL clear only on rst.
REQ-023 When a push and a pop occur in the same cycle, both SHALL take effect and the occupancy SHALL stay unchanged.
REQ-024 cmd_op and cmd_len SHALL be ignored when the handshake does not complete.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set:
- FIFO empty;
- state IDLE, cnt=0;
- j=0, k=0, q_pred=0;
- mismatch=0, cmp_en=0.
REQ-026 Reset asserted mid-DRIVE SHALL discard the active command and all queued commands; no j,k pulse SHALL follow the reset edge.
REQ-027 cmd_ready SHALL be 1 from the first edge after rst deasserts.
REQ-028 q_pred=0 after reset SHALL match the downstream latch's reset value of q=0.

Structure
REQ-029 A shared package jk_pkg SHALL hold:
- the op encodings OP_HOLD, OP_RST, OP_SET, OP_TGL;
- the FSM state enum;
- the command struct {op[1:0], len[2:0]}.
REQ-030 The FIFO SHALL be a separate sub-module, jk_cmd_fifo, parameterised by DEPTH and using the same clk/rst scheme.
REQ-031 The top level SHALL contain only the FSM, the counter, the q_pred/compare logic and the output registers; all outputs except cmd_ready and busy SHALL be registered.

Verification
REQ-032 Push SET len=2 into an idle, empty block at edge 0 -> j=1, k=0 over edges 1-3; j=k=0 at edge 4; q_pred=1 from edge 2.
REQ-033 Push TGL len=3 with q_pred=0 -> q_pred reads 1,0,1,0 on successive edges; final q_pred=0; with q_fb tracking q_pred, mismatch=0.
REQ-034 Push five commands back-to-back with DEPTH=4 while DRIVE runs a len=7 command:
- cmd_ready=0 once 4 entries are queued;
- the fifth command is accepted only after a pop;
- every command executes in order with no idle gap.
REQ-035 Push RST len=0 then SET len=0 consecutively -> j,k read 01 then 10 on adjacent cycles; busy drops the cycle after.
REQ-036 Assert rst for one cycle during the 3rd cycle of a SET len=5 with 2 commands queued:
- after the reset edge, j=k=0, q_pred=0, FIFO empty;
- the discarded commands never appear.
REQ-037 Hold q_fb=0 during SET len=3 -> mismatch=1 from the second edge after q_pred rises; it stays 1 through later matching traffic until rst.
